// File: rtl/mdu_ctrl_if.sv
// Operand, control and result bundle between the E-stage pipeline and the
// multiply/divide unit.
interface mdu_ctrl_if;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        DIsMD;
  logic        Busy;
  logic        MDStall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  modport master (
    output Start, MDOp, A, B, DIsMD,
    input  Busy, MDStall, HI, LO, MDOut
  );

  modport slave (
    input  Start, MDOp, A, B, DIsMD,
    output Busy, MDStall, HI, LO, MDOut
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency busy window over latched
// operands, HI/LO register file and the D-stage stall request.
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic      Clk,
  input  logic      Reset,
  mdu_ctrl_if.slave md
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [31:0]        a_reg, a_next;
  logic [31:0]        b_reg, b_next;
  logic               sgn_reg, sgn_next;
  logic [31:0]        hi_reg, hi_next;
  logic [31:0]        lo_reg, lo_next;

  logic [63:0] prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  // Results are formed only from the latched operands.
  always_comb begin
    prod  = {{32{sgn_reg & a_reg[31]}}, a_reg} * {{32{sgn_reg & b_reg[31]}}, b_reg};
    a_neg = sgn_reg & a_reg[31];
    b_neg = sgn_reg & b_reg[31];
    a_mag = a_neg ? (32'd0 - a_reg) : a_reg;
    b_mag = b_neg ? (32'd0 - b_reg) : b_reg;
    q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    // Magnitude division makes 0x80000000 / -1 wrap to 0x80000000 cleanly.
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sgn_next   = sgn_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (md.Start) begin
          case (md.MDOp)
            OP_MULT, OP_MULTU: begin
              state_next = MUL;
              cnt_next   = CNT_W'(MULT_LAT);
              a_next     = md.A;
              b_next     = md.B;
              sgn_next   = (md.MDOp == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              state_next = DIV;
              cnt_next   = CNT_W'(DIV_LAT);
              a_next     = md.A;
              b_next     = md.B;
              sgn_next   = (md.MDOp == OP_DIV);
            end
            OP_MTHI: hi_next = md.A;
            OP_MTLO: lo_next = md.A;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          if (state_reg == MUL) begin
            hi_next = prod[63:32];
            lo_next = prod[31:0];
          end else if (b_reg != 32'd0) begin
            hi_next = rem;
            lo_next = quot;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sgn_reg   <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sgn_reg   <= sgn_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  logic busy;
  logic start_md;

  always_comb begin
    busy     = (state_reg != IDLE);
    start_md = md.Start && (md.MDOp >= OP_MULT) && (md.MDOp <= OP_DIVU);
    md.Busy    = busy;
    md.MDStall = md.DIsMD & (busy | start_md);
    md.HI      = hi_reg;
    md.LO      = lo_reg;
    case (md.MDOp)
      OP_MFHI: md.MDOut = hi_reg;
      OP_MFLO: md.MDOut = lo_reg;
      default: md.MDOut = 32'd0;
    endcase
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5, meaning busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_LAT, default 10, meaning busy cycles for DIV/DIVU.
REQ-003 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-low reset, sampled on the Clk rising edge.
REQ-005 SHALL have port Start  input  1  E-stage MD-class instruction is valid this cycle.
REQ-006 SHALL have port MDOp  input  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE.
REQ-007 SHALL have port A  input  32  rs operand.
REQ-008 SHALL have port B  input  32  rt operand.
REQ-009 SHALL have port DIsMD  input  1  D-stage instruction is MD-class (any MDOp 1-8).
REQ-010 SHALL have port Busy  output  1  multiply/divide in progress.
REQ-011 SHALL have port MDStall  output  1  freezes the F/D pipeline registers and bubbles E.
REQ-012 SHALL have port HI  output  32  HI register.
REQ-013 SHALL have port LO  output  32  LO register.
REQ-014 SHALL have port MDOut  output  32  read data for MFHI/MFLO.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV, plus a down-counter CNT wide enough for max(MULT_LAT, DIV_LAT).
REQ-016 IDLE, Start=1, MDOp=MULT/MULTU: latch A, B, signedness; go to MUL; CNT=MULT_LAT.
REQ-017 IDLE, Start=1, MDOp=DIV/DIVU: latch A, B, signedness; go to DIV; CNT=DIV_LAT.
REQ-018 In MUL/DIV, CNT SHALL decrement each cycle; on the edge where CNT==1, write results to HI/LO and return to IDLE.
REQ-019 Busy SHALL be 1 exactly while state is MUL or DIV, i.e. for MULT_LAT / DIV_LAT cycles after the Start edge.
REQ-020 MULT: {HI,LO} = signed 64-bit A*B; MULTU: unsigned 64-bit A*B.
REQ-021 DIV: LO=quotient truncated toward zero, HI=remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-023 Divisor zero (DIV/DIVU): SHALL still be busy DIV_LAT cycles, HI and LO unchanged.
REQ-024 MTHI/MTLO with Start=1 in IDLE: HI (resp. LO) = A at the next edge; no busy period.
REQ-025 MDOut = HI when MDOp==MFHI, LO when MDOp==MFLO, else 0; combinational, reflects current register value.
REQ-026 MDStall = DIsMD & (Busy | (Start & MDOp in {MULT,MULTU,DIV,DIVU})).
REQ-027 Start with MDOp 1-8 while Busy SHALL be ignored (no state, counter or HI/LO change).
REQ-028 Start with MDOp NONE, MFHI or MFLO SHALL cause no state change.
REQ-029 Operands SHALL be taken only from the latched copies during MUL/DIV; A/B changes mid-operation have no effect.

Reset
REQ-030 Reset=0 at a rising edge SHALL force state IDLE, CNT=0, HI=0, LO=0, latched operands=0.
REQ-031 After that edge Busy=0, MDStall=DIsMD & Start & (MDOp in 1-4), MDOut=0.
REQ-032 Reset=0 during MUL/DIV SHALL abort the operation; HI/LO SHALL read 0, not the pending result.
REQ-033 Reset SHALL take priority over Start on the same edge.

Verification
REQ-034 MULT A=0xFFFFFFFE, B=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x2, LO=0xFFFFFFFA.
REQ-035 DIV A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI/LO unchanged after 10 cycles.
REQ-036 MULT start with DIsMD=1 held -> MDStall=1 on the Start cycle and all 5 busy cycles, 0 on the cycle after Busy falls; DIsMD=0 -> MDStall stays 0.
REQ-037 MTHI A=0x12345678, then MFHI -> MDOut=0x12345678 next cycle; MTLO A=0xCAFE then MFLO -> MDOut=0x0000CAFE.
REQ-038 DIV started, Reset=0 at busy cycle 4 -> next cycle Busy=0, HI=LO=0; a second Start during busy (with Reset held 1) -> ignored, original result intact.
